// File: rtl/clock_pkg.sv
// Shared types and constants for the time_counter slice.
// The run/pause/load state type, the 59 limits for seconds and minutes,
// the field widths, and a range-check helper used by the load path.
package clock_pkg;

  // Operating state of the time counter.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    LOAD   = 2'd2
  } state_t;

  // Field widths for hours and for minutes/seconds.
  localparam int HH_W = 5;
  localparam int MS_W = 6;

  // Last legal value of the seconds and minutes fields.
  localparam logic [MS_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MS_W-1:0] MIN_MAX = 6'd59;

  // True when a seconds or minutes value is inside 0..59.
  function automatic logic ms_in_range(input logic [MS_W-1:0] v);
    return (v <= SEC_MAX);
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for the divided rate signal.
// tick_in is already synchronous to clk; it is only sampled, never used as
// a clock. rise is high in the cycle where tick_in=1 and the registered copy
// is still 0, so a consumer acts on the same clk edge that samples the rise.
module tick_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic rise
);

  logic tick_d;

  // Delayed copy of tick_in used as the previous-cycle reference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_d <= 1'b0;
    end else begin
      tick_d <= tick_in;
    end
  end

  assign rise = tick_in & ~tick_d;

endmodule

// File: rtl/time_counter.sv
// hh:mm:ss timekeeper driven by the clock-divider rate signal.
// Rises of tick_in are prescaled by TICKS_PER_SEC into second advances, with
// pause control, a valid/ready time-load port and carry pulses downstream.
// Optional alarm output is compiled in when the ALARM_EN macro is defined.
//
// Handshake: a load is accepted on a clk edge where set_valid and set_ready
// are both 1. set_ready is 1 in RUN and PAUSED and 0 in LOAD or while rst is
// asserted; the requester must hold set_hh/mm/ss stable while set_valid=1.
// An accepted out-of-range load leaves the time untouched and answers with a
// one-cycle set_err pulse instead of entering LOAD.
//
// state and sub are exported so checkers can observe the FSM and prescaler.
module time_counter
  import clock_pkg::*;
#(
  parameter  int TICKS_PER_SEC = 1,
  parameter  int HOURS_MAX     = 24,
  localparam int SUB_W         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick_in,
  input  logic            pause,
  input  logic            set_valid,
  output logic            set_ready,
  input  logic [HH_W-1:0] set_hh,
  input  logic [MS_W-1:0] set_mm,
  input  logic [MS_W-1:0] set_ss,
  output logic            set_err,
  output logic [HH_W-1:0] hh,
  output logic [MS_W-1:0] mm,
  output logic [MS_W-1:0] ss,
  output logic            sec_pulse,
  output logic            day_pulse,
`ifdef ALARM_EN
  input  logic            alarm_on,
  input  logic [HH_W-1:0] alarm_hh,
  input  logic [MS_W-1:0] alarm_mm,
  output logic            alarm_pulse,
`endif
  output state_t          state,
  output logic [SUB_W-1:0] sub
);

  localparam logic [HH_W-1:0]  HH_LAST  = HH_W'(HOURS_MAX - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);

  logic            rise;
  logic            accept;
  logic            set_ok;
  logic            count_en;
  logic            sub_last;
  logic            ss_at_max;
  logic            mm_at_max;
  logic            hh_at_max;
  logic            wrap_day;
  logic [HH_W-1:0] hh_nxt;
  logic [MS_W-1:0] mm_nxt;
  logic [MS_W-1:0] ss_nxt;

  tick_edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .tick_in (tick_in),
    .rise    (rise)
  );

  // Ready whenever not in the one-cycle LOAD state and not held in reset.
  assign set_ready = ~rst & (state != LOAD);
  assign accept    = set_valid & set_ready;
  assign set_ok    = ms_in_range(set_ss) & ms_in_range(set_mm) & (set_hh <= HH_LAST);

  // Next time-of-day values for a second advance, plus prescaler and count gating.
  always_comb begin
    ss_at_max = (ss == SEC_MAX);
    mm_at_max = (mm == MIN_MAX);
    hh_at_max = (hh == HH_LAST);
    wrap_day  = ss_at_max & mm_at_max & hh_at_max;
    ss_nxt    = ss_at_max ? '0 : ss + MS_W'(1);
    mm_nxt    = mm;
    hh_nxt    = hh;
    if (ss_at_max) begin
      mm_nxt = mm_at_max ? '0 : mm + MS_W'(1);
      if (mm_at_max) begin
        hh_nxt = hh_at_max ? '0 : hh + HH_W'(1);
      end
    end
    sub_last = (sub == SUB_LAST);
    // A rise only counts in RUN; an accepted good load takes priority.
    count_en = (state == RUN) & rise & ~(accept & set_ok);
  end

  // Main FSM: state, time fields, prescaler and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      hh        <= '0;
      mm        <= '0;
      ss        <= '0;
      sub       <= '0;
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
      set_err   <= 1'b0;
      case (state)
        RUN, PAUSED: begin
          if (accept && set_ok) begin
            hh    <= set_hh;
            mm    <= set_mm;
            ss    <= set_ss;
            sub   <= '0;
            state <= LOAD;
          end else begin
            if (accept) begin
              set_err <= 1'b1;
            end
            if (count_en) begin
              if (sub_last) begin
                sub       <= '0;
                ss        <= ss_nxt;
                mm        <= mm_nxt;
                hh        <= hh_nxt;
                sec_pulse <= 1'b1;
                day_pulse <= wrap_day;
              end else begin
                sub <= sub + SUB_W'(1);
              end
            end
            if (state == RUN && pause) begin
              state <= PAUSED;
            end else if (state == PAUSED && !pause) begin
              state <= RUN;
            end
          end
        end
        LOAD: begin
          state <= pause ? PAUSED : RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef ALARM_EN
  // Alarm fires only from a counted second advance landing on hh:mm:00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_pulse <= 1'b0;
    end else begin
      alarm_pulse <= count_en & sub_last & alarm_on &
                     (hh_nxt == alarm_hh) & (mm_nxt == alarm_mm) & (ss_nxt == '0);
    end
  end
`endif

endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
- Consumer end of the clock-divider output: takes the divided square-wave rate signal (1/10/100/1000 Hz) and turns it into hours:minutes:seconds timekeeping.
- Rising-edge detects the rate signal in the system clock domain; it never uses it as a clock.
- Provides a valid/ready time-set interface, a pause control, and carry pulses for downstream display and calendar logic.

Parameters:
- TICKS_PER_SEC, 1, rising edges of tick_in per second advance (1 = one edge per second).
- HOURS_MAX, 24, hour modulus; hour counts 0..HOURS_MAX-1.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  asynchronous, active-high reset.
- tick_in  in  1  divided square-wave rate from the clock divider, synchronous to clk.
- pause  in  1  level; 1 = freeze time advance.
- set_valid  in  1  time-load request.
- set_ready  out  1  block can accept a load.
- set_hh  in  5  hour to load.
- set_mm  in  6  minute to load.
- set_ss  in  6  second to load.
- set_err  out  1  one-cycle pulse: the load was rejected as out of range.
- hh  out  5  current hour.
- mm  out  6  current minute.
- ss  out  6  current second.
- sec_pulse  out  1  one-cycle pulse on every second advance.
- day_pulse  out  1  one-cycle pulse on the wrap from (HOURS_MAX-1):59:59 to 00:00:00.

Behaviour:
- Reset (async, rst=1) clears everything to 0 immediately: hh, mm, ss, sub-counter, tick_d, sec_pulse, day_pulse, set_err. State goes to RUN; set_ready=1 after reset.
- Edge detect: tick_d registers tick_in. A rise is tick_in=1 and tick_d=0. Counters update at the same clk edge the rise is sampled.
- Prescale: sub-counter runs 0..TICKS_PER_SEC-1 and increments on each accepted rise. On a rise with sub=TICKS_PER_SEC-1: sub wraps to 0 and the second advances.
- Second advance:
  - ss increments, wrapping 59->0 with carry to mm.
  - mm wraps 59->0 with carry to hh.
  - hh wraps HOURS_MAX-1->0.
  - sec_pulse=1 for one cycle on every advance; day_pulse=1 for one cycle only on the full wrap.
- FSM states: RUN, PAUSED, LOAD.
  - RUN: rises are counted. Goes to PAUSED when pause=1.
  - PAUSED: rises are ignored (tick_d still tracks); sub, hh, mm, ss hold. Goes to RUN when pause=0.
  - Set accept: in RUN or PAUSED, set_valid and set_ready at the same edge is an accept.
    - Range check: set_ss<60, set_mm<60, set_hh<HOURS_MAX.
    - Valid: hh/mm/ss load, sub clears to 0, state goes to LOAD.
    - Invalid: no change, set_err pulses 1 cycle, state is unchanged.
  - LOAD: set_ready=0; rises are ignored; lasts exactly 1 cycle, then RUN if pause=0, else PAUSED.
- set_ready=1 in RUN and PAUSED, 0 in LOAD and during reset.
- Simultaneous accepted set and rise: the set wins and the rise is discarded (no sec_pulse).
- pause change and rise in the same cycle: the state sampled at that edge governs, so a rise while in RUN counts.
- Reset mid-load: the load is lost; outputs return to 0.
- All arithmetic is unsigned and exact-width; no out-of-range value is ever reachable.

Optional Feature:
- Macro ALARM_EN.
- Defined: adds ports alarm_on (in 1), alarm_hh (in 5), alarm_mm (in 6), alarm_pulse (out 1, reset 0).
  - alarm_pulse=1 for one cycle when a second advance produces hh=alarm_hh, mm=alarm_mm, ss=0 while alarm_on=1.
  - A load never triggers it.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package clock_pkg holds:
  - state enum {RUN, PAUSED, LOAD};
  - constants SEC_MAX=59 and MIN_MAX=59;
  - width constants HH_W=5 and MS_W=6.
- One sub-module, tick_edge_detect: clk, rst, tick_in -> rise. It is reusable by other consumers of the divider output.

Test Plan:
- Reset, TICKS_PER_SEC=1, 3 tick_in rises -> ss=3, 3 sec_pulses, hh=mm=0, no day_pulse.
- Load 23:59:58 (HOURS_MAX=24), then 2 rises -> second rise yields 00:00:00 with day_pulse=1 in the same cycle as sec_pulse.
- pause=1, 5 rises, pause=0, 1 rise -> ss advances by exactly 1.
- set_ss=60 with set_valid -> set_err pulse, time unchanged, set_ready stays 1. Then a valid load plus a simultaneous rise -> loaded value held, no sec_pulse, set_ready=0 for one cycle.
- TICKS_PER_SEC=10, 25 rises -> ss=2, sub=5. Then load 00:00:00 -> the next 10 rises give ss=1.
- ALARM_EN, alarm 00:01 on, start at 00:00:59, 1 rise -> alarm_pulse=1 for one cycle. Then load 00:01:00 -> no alarm_pulse.
